// File: rtl/fp_cmp96_resolve.sv
// rtl/fp_cmp96_resolve.sv - FP96 compare result resolver with 2-entry output queue
// Optional invalid-event counter built when FPCMP96_INVCNT_EN is defined.
module fp_cmp96_resolve #(
  parameter int TAGW = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     cmp_o,
  input  logic            cmp_nan,
  input  logic            cmp_snan,
  input  logic            cmp_inf,
  input  logic [3:0]      cond,
  input  logic            signaling,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_cc,
  output logic [15:0]     out_vec,
  output logic            out_inv,
  output logic            out_nan,
  output logic [TAGW-1:0] out_tag,
  input  logic            flags_clr,
  output logic            sticky_inv,
  output logic            sticky_snan,
  output logic [CNTW-1:0] inv_cnt
);

  // Entry layout: {cc, vec[15:0], inv, nan, tag}
  localparam int EW = 19 + TAGW;

  logic [EW-1:0] head_q, tail_q, new_e;
  logic [1:0]    count_q;
  logic          cond_ok, new_cc, new_inv, accept, pop;
  logic          unused_inf;

  assign unused_inf = cmp_inf;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12: cond_ok = 1'b1;
      default:                         cond_ok = 1'b0;
    endcase
  end

  assign new_cc  = cond_ok & cmp_o[cond];
  assign new_inv = cmp_snan | (signaling & cmp_o[4]);
  assign new_e   = {new_cc, cmp_o, new_inv, cmp_nan, in_tag};

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head register doubles as the output stage; it keeps the last popped entry when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (accept) begin
            head_q  <= new_e;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head_q <= new_e;
          end else if (accept) begin
            tail_q  <= new_e;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

  assign out_cc  = head_q[EW-1];
  assign out_vec = head_q[EW-2 -: 16];
  assign out_inv = head_q[TAGW+1];
  assign out_nan = head_q[TAGW];
  assign out_tag = head_q[TAGW-1:0];

  // A new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_inv  <= 1'b0;
      sticky_snan <= 1'b0;
    end else begin
      sticky_inv  <= (sticky_inv  & ~flags_clr) | (accept & new_inv);
      sticky_snan <= (sticky_snan & ~flags_clr) | (accept & cmp_snan);
    end
  end

`ifdef FPCMP96_INVCNT_EN
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && new_inv) begin
      if (flags_clr)
        cnt_q <= CNTW'(1);
      else if (cnt_q != {CNTW{1'b1}})
        cnt_q <= cnt_q + CNTW'(1);
    end else if (flags_clr) begin
      cnt_q <= '0;
    end
  end

  assign inv_cnt = cnt_q;
`else
  assign inv_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_cmp96_resolve.sv
// tb/tb_fp_cmp96_resolve.sv - directed self-checking bench for fp_cmp96_resolve
module tb_fp_cmp96_resolve;

  localparam int TAGW = 4;
  localparam int CNTW = 2;
`ifdef FPCMP96_INVCNT_EN
  localparam logic [CNTW-1:0] SAT_EXP = 2'd3;
  localparam logic [CNTW-1:0] ONE_EXP = 2'd1;
`else
  localparam logic [CNTW-1:0] SAT_EXP = 2'd0;
  localparam logic [CNTW-1:0] ONE_EXP = 2'd0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [15:0]     cmp_o = '0;
  logic            cmp_nan = 1'b0;
  logic            cmp_snan = 1'b0;
  logic            cmp_inf = 1'b0;
  logic [3:0]      cond = '0;
  logic            signaling = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_cc;
  logic [15:0]     out_vec;
  logic            out_inv;
  logic            out_nan;
  logic [TAGW-1:0] out_tag;
  logic            flags_clr = 1'b0;
  logic            sticky_inv;
  logic            sticky_snan;
  logic [CNTW-1:0] inv_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_cmp96_resolve #(.TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmp_o(cmp_o), .cmp_nan(cmp_nan), .cmp_snan(cmp_snan), .cmp_inf(cmp_inf),
    .cond(cond), .signaling(signaling), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_cc(out_cc), .out_vec(out_vec), .out_inv(out_inv),
    .out_nan(out_nan), .out_tag(out_tag), .flags_clr(flags_clr),
    .sticky_inv(sticky_inv), .sticky_snan(sticky_snan), .inv_cnt(inv_cnt)
  );

  task automatic send(input logic [15:0] v, input logic [3:0] c, input logic sig,
                      input logic sn, input logic nn, input logic inf, input logic [TAGW-1:0] t);
    in_valid  = 1'b1;
    cmp_o     = v;
    cond      = c;
    signaling = sig;
    cmp_snan  = sn;
    cmp_nan   = nn;
    cmp_inf   = inf;
    in_tag    = t;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cmp_o = '0; cond = '0; signaling = 1'b0; cmp_snan = 1'b0; cmp_nan = 1'b0; cmp_inf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if ({out_cc, out_vec, out_inv, out_nan, out_tag} !== '0 || sticky_inv !== 1'b0 ||
        sticky_snan !== 1'b0 || inv_cnt !== '0) begin
      errors++; $display("FAIL reset_vals: cc=%b vec=%h inv=%b nan=%b tag=%h si=%b ss=%b cnt=%0d want all 0",
                         out_cc, out_vec, out_inv, out_nan, out_tag, sticky_inv, sticky_snan, inv_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    send(16'h0207, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    @(negedge clk);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_cc !== 1'b1 || out_tag !== 4'd5 || out_vec !== 16'h0207 ||
        out_inv !== 1'b0 || out_nan !== 1'b0) begin
      errors++; $display("FAIL basic: valid=%b cc=%b tag=%h vec=%h inv=%b nan=%b want 1/1/5/0207/0/0",
                         out_valid, out_cc, out_tag, out_vec, out_inv, out_nan);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_tag !== 4'd5 || out_cc !== 1'b1) begin
      errors++; $display("FAIL basic_empty_hold: valid=%b tag=%h cc=%b want 0/5/1", out_valid, out_tag, out_cc);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    @(negedge clk);
    send(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    send(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    @(negedge clk);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_cc !== 1'b1) begin
      errors++; $display("FAIL bp_hold: valid=%b tag=%h cc=%b want 1/1/1", out_valid, out_tag, out_cc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_cc !== 1'b0) begin
      errors++; $display("FAIL bp_second: valid=%b tag=%h cc=%b want 1/2/0", out_valid, out_tag, out_cc);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_tag !== 4'd2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_drained: valid=%b tag=%h in_ready=%b want 0/2/1", out_valid, out_tag, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(6 + i));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'(6 + i)) begin
        errors++; $display("FAIL b2b_%0d: valid=%b tag=%h want 1/%h", i, out_valid, out_tag, 4'(6 + i));
      end
    end
    idle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_cond();
    logic [3:0] cs [3];
    logic       ex [3];
    cs = '{4'd5, 4'd12, 4'd13};
    ex = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(16'hFFFF, cs[i], 1'b0, 1'b0, 1'b0, 1'b0, 4'(i));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_cc !== ex[i]) begin
        errors++; $display("FAIL cond_%0d: valid=%b cc=%b want 1/%b", cs[i], out_valid, out_cc, ex[i]);
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    send(16'h0010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    checks++;
    if (out_inv !== 1'b0 || out_cc !== 1'b1 || sticky_inv !== 1'b0) begin
      errors++; $display("FAIL inv_quiet: inv=%b cc=%b sticky=%b want 0/1/0", out_inv, out_cc, sticky_inv);
    end
    send(16'h0010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    @(negedge clk);
    checks++;
    if (out_inv !== 1'b1 || sticky_inv !== 1'b1 || sticky_snan !== 1'b0) begin
      errors++; $display("FAIL inv_signal: inv=%b si=%b ss=%b want 1/1/0", out_inv, sticky_inv, sticky_snan);
    end
    send(16'h0001, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
    @(negedge clk);
    idle();
    checks++;
    if (out_inv !== 1'b0 || out_nan !== 1'b1 || sticky_inv !== 1'b1) begin
      errors++; $display("FAIL inv_inf: inv=%b nan=%b si=%b want 0/1/1", out_inv, out_nan, sticky_inv);
    end
    @(negedge clk);
  endtask

  task automatic test_clr_set();
    out_ready = 1'b1;
    flags_clr = 1'b1;
    send(16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    @(negedge clk);
    idle();
    checks++;
    if (sticky_inv !== 1'b1 || sticky_snan !== 1'b1 || out_inv !== 1'b1) begin
      errors++; $display("FAIL clr_set: si=%b ss=%b inv=%b want 1/1/1", sticky_inv, sticky_snan, out_inv);
    end
    @(negedge clk);
    flags_clr = 1'b0;
    checks++;
    if (sticky_inv !== 1'b0 || sticky_snan !== 1'b0) begin
      errors++; $display("FAIL clr_only: si=%b ss=%b want 0/0", sticky_inv, sticky_snan);
    end
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    checks++;
    if (inv_cnt !== '0) begin
      errors++; $display("FAIL cnt_clear: cnt=%0d want 0", inv_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      send(16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(i));
      @(negedge clk);
    end
    checks++;
    if (inv_cnt !== SAT_EXP) begin
      errors++; $display("FAIL cnt_sat: cnt=%0d want %0d", inv_cnt, SAT_EXP);
    end
    flags_clr = 1'b1;
    @(negedge clk);
    idle();
    checks++;
    if (inv_cnt !== ONE_EXP) begin
      errors++; $display("FAIL cnt_clr_inc: cnt=%0d want %0d", inv_cnt, ONE_EXP);
    end
    @(negedge clk);
    flags_clr = 1'b0;
    checks++;
    if (inv_cnt !== '0) begin
      errors++; $display("FAIL cnt_clr: cnt=%0d want 0", inv_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(16'h0001, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
    @(negedge clk);
    send(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10);
    @(negedge clk);
    idle();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pre: valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_tag !== '0 || in_ready !== 1'b1 || sticky_snan !== 1'b0 || out_cc !== 1'b0) begin
      errors++; $display("FAIL rst_async: valid=%b tag=%h in_ready=%b ss=%b cc=%b want 0/0/1/0/0",
                         out_valid, out_tag, in_ready, sticky_snan, out_cc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_discard: valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_cond();
    test_invalid();
    test_clr_set();
    test_counter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
